// File: rtl/vga_pkg.sv
// Shared VGA 640x480@60 timing constants, coordinate and colour types for the
// frogger display path.
package vga_pkg;

  localparam int H_VISIBLE = 640;
  localparam int H_FP      = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BP      = 48;
  localparam int H_TOTAL   = H_VISIBLE + H_FP + H_SYNC + H_BP;

  localparam int V_VISIBLE = 480;
  localparam int V_FP      = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BP      = 33;
  localparam int V_TOTAL   = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam int H_SYNC_START = H_VISIBLE + H_FP;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
  localparam int V_SYNC_START = V_VISIBLE + V_FP;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

  localparam int CLK_DIV = 2;

  typedef logic [10:0] coord_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  // Half-open window test [lo, hi) on a raster coordinate.
  function automatic logic in_window(coord_t v, int lo, int hi);
    return (v >= coord_t'(lo)) && (v < coord_t'(hi));
  endfunction

endpackage

// File: rtl/vga_clk_div.sv
// Pixel-rate divider: a one-Clk pixel enable (pe) on the last Clk of every
// pixel, and a registered ~50% duty VGA_CLK for the DAC.
module vga_clk_div #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  output logic pe,
  output logic vga_clk
);

  localparam int DW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  typedef logic [DW-1:0] div_t;

  div_t div;
  div_t div_next;

  assign pe       = (div == div_t'(CLK_DIV - 1));
  assign div_next = pe ? '0 : div + div_t'(1);

  // vga_clk is computed from div_next so the register mirrors the current div
  // phase: low for the first half of a pixel, high for the second.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div     <= '0;
      vga_clk <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments in clocked blocks so every register
      // samples pre-edge values regardless of statement order.
      div     <= div_next;
      vga_clk <= (div_next >= div_t'(CLK_DIV / 2));
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Raster source and video sink: DrawX/DrawY to color_mapper, registered colour
// aligned with HS/VS/BLANK_N one pixel later, and a per-frame frame_start pulse.
module vga_timing_gen
  import vga_pkg::coord_t, vga_pkg::rgb_t, vga_pkg::in_window;
#(
  parameter int CLK_DIV   = vga_pkg::CLK_DIV,
  parameter int H_VISIBLE = vga_pkg::H_VISIBLE,
  parameter int H_FP      = vga_pkg::H_FP,
  parameter int H_SYNC    = vga_pkg::H_SYNC,
  parameter int H_BP      = vga_pkg::H_BP,
  parameter int V_VISIBLE = vga_pkg::V_VISIBLE,
  parameter int V_FP      = vga_pkg::V_FP,
  parameter int V_SYNC    = vga_pkg::V_SYNC,
  parameter int V_BP      = vga_pkg::V_BP
) (
  input  logic       Clk,
  input  logic       Reset_n,
  output coord_t     DrawX,
  output coord_t     DrawY,
  input  logic [7:0] Red_in,
  input  logic [7:0] Green_in,
  input  logic [7:0] Blue_in,
  output logic [7:0] VGA_R,
  output logic [7:0] VGA_G,
  output logic [7:0] VGA_B,
  output logic       VGA_HS,
  output logic       VGA_VS,
  output logic       VGA_BLANK_N,
  output logic       VGA_CLK,
  output logic       frame_start
);

  localparam int H_TOTAL      = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL      = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int H_SYNC_START = H_VISIBLE + H_FP;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
  localparam int V_SYNC_START = V_VISIBLE + V_FP;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

  logic   pe;
  coord_t hc;
  coord_t vc;
  coord_t hc_next;
  coord_t vc_next;
  logic   h_last;
  logic   v_last;
  logic   vis;
  logic   h_sync;
  logic   v_sync;
  rgb_t   pix_in;
  rgb_t   pix_q;

  vga_clk_div #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_div (
    .clk     (Clk),
    .rst_n   (Reset_n),
    .pe      (pe),
    .vga_clk (VGA_CLK)
  );

  // ---------------------------------------------------------------------------
  // Raster counters: advance once per pixel, vc steps when hc wraps.
  // ---------------------------------------------------------------------------
  assign h_last = (hc == coord_t'(H_TOTAL - 1));
  assign v_last = (vc == coord_t'(V_TOTAL - 1));

  always_comb begin
    // NOTE: defaults first in always_comb so no path can leave a variable
    // unassigned and infer a latch.
    hc_next = hc;
    vc_next = vc;
    if (pe) begin
      hc_next = h_last ? '0 : hc + coord_t'(1);
      if (h_last) begin
        vc_next = v_last ? '0 : vc + coord_t'(1);
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      hc <= '0;
      vc <= '0;
    end else begin
      hc <= hc_next;
      vc <= vc_next;
    end
  end

  assign DrawX = hc;
  assign DrawY = vc;

  // ---------------------------------------------------------------------------
  // Output stage: colour returned by color_mapper for (hc,vc) is registered on
  // the pe that leaves that pixel, so sync/blank are registered alongside it.
  // ---------------------------------------------------------------------------
  assign vis    = (hc < coord_t'(H_VISIBLE)) && (vc < coord_t'(V_VISIBLE));
  assign h_sync = in_window(hc, H_SYNC_START, H_SYNC_END);
  assign v_sync = in_window(vc, V_SYNC_START, V_SYNC_END);
  assign pix_in = '{r: Red_in, g: Green_in, b: Blue_in};

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      pix_q       <= '0;
      VGA_HS      <= 1'b1;
      VGA_VS      <= 1'b1;
      VGA_BLANK_N <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      // One Clk wide: only the pe that wraps (799,524) -> (0,0) raises it.
      frame_start <= pe && h_last && v_last;
      if (pe) begin
        pix_q       <= vis ? pix_in : '0;
        VGA_HS      <= ~h_sync;
        VGA_VS      <= ~v_sync;
        VGA_BLANK_N <= vis;
      end
    end
  end

  assign VGA_R = pix_q.r;
  assign VGA_G = pix_q.g;
  assign VGA_B = pix_q.b;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a full-size instance (CLK_DIV=2) and a reduced-
// geometry instance (CLK_DIV=4) checked every Clk against an arithmetic model.
`timescale 1ns/1ps
module tb_vga_timing_gen;

  // Instance A: default 640x480 timing, CLK_DIV = 2.
  localparam int DA = 2, HVA = 640, HFA = 16, HSA = 96, HBA = 48;
  localparam int VVA = 480, VFA = 10, VSA = 2, VBA = 33;
  // Instance B: small raster (35 x 19 pixels) so whole frames fit the run.
  localparam int DB = 4, HVB = 20, HFB = 4, HSB = 6, HBB = 5;
  localparam int VVB = 12, VFB = 2, VSB = 2, VBB = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #10 clk = ~clk;

  logic [10:0] draw_x_a, draw_y_a, draw_x_b, draw_y_b;
  logic [7:0]  red_a = 8'h00, green_a = 8'h00, blue_a = 8'h00;
  logic [7:0]  red_b = 8'h00, green_b = 8'h00, blue_b = 8'h00;
  logic [7:0]  vga_r_a, vga_g_a, vga_b_a, vga_r_b, vga_g_b, vga_b_b;
  logic        hs_a, vs_a, bn_a, vclk_a, fs_a;
  logic        hs_b, vs_b, bn_b, vclk_b, fs_b;

  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          ka = 0;
  int          kb = 0;
  logic [23:0] samp_a = '0;
  logic [23:0] samp_b = '0;
  int          mode_a = 2;
  int          rel_cyc = 0;
  bit          released = 1'b0;

  vga_timing_gen dut_a (
    .Clk (clk), .Reset_n (rst_n),
    .DrawX (draw_x_a), .DrawY (draw_y_a),
    .Red_in (red_a), .Green_in (green_a), .Blue_in (blue_a),
    .VGA_R (vga_r_a), .VGA_G (vga_g_a), .VGA_B (vga_b_a),
    .VGA_HS (hs_a), .VGA_VS (vs_a), .VGA_BLANK_N (bn_a),
    .VGA_CLK (vclk_a), .frame_start (fs_a)
  );

  vga_timing_gen #(
    .CLK_DIV (DB), .H_VISIBLE (HVB), .H_FP (HFB), .H_SYNC (HSB), .H_BP (HBB),
    .V_VISIBLE (VVB), .V_FP (VFB), .V_SYNC (VSB), .V_BP (VBB)
  ) dut_b (
    .Clk (clk), .Reset_n (rst_n),
    .DrawX (draw_x_b), .DrawY (draw_y_b),
    .Red_in (red_b), .Green_in (green_b), .Blue_in (blue_b),
    .VGA_R (vga_r_b), .VGA_G (vga_g_b), .VGA_B (vga_b_b),
    .VGA_HS (hs_b), .VGA_VS (vs_b), .VGA_BLANK_N (bn_b),
    .VGA_CLK (vclk_b), .frame_start (fs_b)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Expected outputs after k Clk edges since reset release. n pixels have
  // elapsed; outputs describe pixel n-1, coloured with the last sampled input.
  function automatic logic [50:0] model(int k, int d, int hv, int hfp, int hsy, int hbp,
                                        int vv, int vfp, int vsy, int vbp, logic [23:0] rgb);
    int ht, vt, n, m, px, py;
    bit vis, hs, vs, vclk, fs;
    logic [23:0] col;
    logic [10:0] x, y;
    ht   = hv + hfp + hsy + hbp;
    vt   = vv + vfp + vsy + vbp;
    n    = k / d;
    x    = 11'(n % ht);
    y    = 11'((n / ht) % vt);
    vclk = (k % d) >= d / 2;
    fs   = (k % d == 0) && (n > 0) && (n % (ht * vt) == 0);
    if (n == 0) begin
      hs = 1'b1; vs = 1'b1; vis = 1'b0;
    end else begin
      m   = n - 1;
      px  = m % ht;
      py  = (m / ht) % vt;
      vis = (px < hv) && (py < vv);
      hs  = !((px >= hv + hfp) && (px < hv + hfp + hsy));
      vs  = !((py >= vv + vfp) && (py < vv + vfp + vsy));
    end
    col = vis ? rgb : 24'h0;
    return {x, y, col, hs, vs, vis, vclk, fs};
  endfunction

  always @(posedge clk) cyc++;

  // Model time base: Clk edges since release, plus colour seen on pixel edges.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ka = 0; kb = 0; samp_a = '0; samp_b = '0;
    end else begin
      ka++; kb++;
      if (ka % DA == 0) samp_a = {red_a, green_a, blue_a};
      if (kb % DB == 0) samp_b = {red_b, green_b, blue_b};
    end
  end

  always @(negedge clk) begin
    case (mode_a)
      0: begin red_a = 8'($urandom); green_a = 8'($urandom); blue_a = 8'($urandom); end
      1: begin red_a = draw_x_a[7:0]; green_a = 8'($urandom); blue_a = 8'($urandom); end
      default: begin red_a = 8'hAA; green_a = 8'hAA; blue_a = 8'hAA; end
    endcase
    red_b = 8'($urandom); green_b = 8'($urandom); blue_b = 8'($urandom);
  end

  // Every-cycle compare against the model.
  always @(negedge clk) begin
    check("raster_a", 64'({draw_x_a, draw_y_a, vga_r_a, vga_g_a, vga_b_a, hs_a, vs_a, bn_a, vclk_a, fs_a}),
          64'(model(ka, DA, HVA, HFA, HSA, HBA, VVA, VFA, VSA, VBA, samp_a)));
    check("raster_b", 64'({draw_x_b, draw_y_b, vga_r_b, vga_g_b, vga_b_b, hs_b, vs_b, bn_b, vclk_b, fs_b}),
          64'(model(kb, DB, HVB, HFB, HSB, HBB, VVB, VFB, VSB, VBB, samp_b)));
  end

  localparam logic [50:0] RESET_VEC = {11'd0, 11'd0, 24'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

  // Main sequence: instance A checks, then mid-frame reset.
  initial begin
    int n, c1, c2;
    logic [10:0] xm1;
    repeat (3) @(negedge clk);
    check("reset_a", 64'({draw_x_a, draw_y_a, vga_r_a, vga_g_a, vga_b_a, hs_a, vs_a, bn_a, vclk_a, fs_a}), 64'(RESET_VEC));
    check("reset_b", 64'({draw_x_b, draw_y_b, vga_r_b, vga_g_b, vga_b_b, hs_b, vs_b, bn_b, vclk_b, fs_b}), 64'(RESET_VEC));
    rst_n = 1'b1;
    rel_cyc = cyc;
    released = 1'b1;

    @(posedge clk); #1;
    check("first_edge_x", 64'(draw_x_a), 64'd0);
    @(posedge clk); #1;
    check("first_pe_x", 64'(draw_x_a), 64'd1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("pe2_x", 64'(draw_x_a), 64'd2);
    check("aa_red", 64'(vga_r_a), 64'hAA);
    check("aa_blank_n", 64'(bn_a), 64'd1);
    mode_a = 0;

    n = 0;
    while (hs_a !== 1'b0 && n < 2000) begin @(negedge clk); n++; end
    check("hs_fall_seen", 64'(hs_a), 64'd0);
    check("hs_fall_x", 64'(draw_x_a), 64'd657);
    check("hs_fall_y", 64'(draw_y_a), 64'd0);
    n = 0;
    while (hs_a === 1'b0 && n < 1000) begin n++; @(negedge clk); end
    check("hs_low_cycles", 64'(n), 64'd192);

    n = 0;
    while (draw_y_a !== 11'd1 && n < 3000) begin @(negedge clk); n++; end
    c1 = cyc;
    n = 0;
    while (draw_y_a !== 11'd2 && n < 3000) begin @(negedge clk); n++; end
    c2 = cyc;
    check("line_period_a", 64'(c2 - c1), 64'd1600);

    mode_a = 1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 1700; i++) begin
      @(negedge clk);
      xm1 = draw_x_a - 11'd1;
      if (bn_a) check("red_prev_x", 64'(vga_r_a), 64'(xm1[7:0]));
      else      check("red_blank", 64'(vga_r_a), 64'd0);
    end
    mode_a = 0;

    n = 0;
    while (!(draw_x_b === 11'd10 && draw_y_b === 11'd5) && n < 3000) begin @(negedge clk); n++; end
    check("reset_point", 64'({draw_x_b, draw_y_b}), 64'({11'd10, 11'd5}));
    @(posedge clk); #5;
    rst_n = 1'b0;
    #1;
    check("midreset_a", 64'({draw_x_a, draw_y_a, vga_r_a, vga_g_a, vga_b_a, hs_a, vs_a, bn_a, vclk_a, fs_a}), 64'(RESET_VEC));
    check("midreset_b", 64'({draw_x_b, draw_y_b, vga_r_b, vga_g_b, vga_b_b, hs_b, vs_b, bn_b, vclk_b, fs_b}), 64'(RESET_VEC));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    rel_cyc = cyc;
    @(posedge clk); #1;
    check("restart_xy_b", 64'({draw_x_b, draw_y_b}), 64'd0);
    n = 0;
    while (fs_b !== 1'b1 && n < 3000) begin @(negedge clk); n++; end
    check("fs_after_reset", 64'(cyc - rel_cyc), 64'd2660);

    repeat (10) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Instance B: divider waveform, line period, vertical sync, first frame_start.
  initial begin
    int n, hi, lo, c1, c2;
    wait (released);
    n = 0;
    while (vclk_b !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    hi = 0;
    while (vclk_b === 1'b1 && hi < 20) begin hi++; @(negedge clk); end
    lo = 0;
    while (vclk_b === 1'b0 && lo < 20) begin lo++; @(negedge clk); end
    check("vclk_high_b", 64'(hi), 64'd2);
    check("vclk_low_b", 64'(lo), 64'd2);

    n = 0;
    while (draw_y_b !== 11'd1 && n < 3000) begin @(negedge clk); n++; end
    c1 = cyc;
    n = 0;
    while (draw_y_b !== 11'd2 && n < 3000) begin @(negedge clk); n++; end
    c2 = cyc;
    check("line_period_b", 64'(c2 - c1), 64'd140);

    n = 0;
    while (vs_b !== 1'b0 && n < 3000) begin @(negedge clk); n++; end
    check("vs_fall_xy", 64'({draw_x_b, draw_y_b}), 64'({11'd1, 11'd14}));
    n = 0;
    while (vs_b === 1'b0 && n < 1000) begin n++; @(negedge clk); end
    check("vs_low_cycles", 64'(n), 64'd280);

    n = 0;
    while (fs_b !== 1'b1 && n < 3000) begin @(negedge clk); n++; end
    check("first_fs_b", 64'(cyc - rel_cyc), 64'd2660);
    @(negedge clk);
    check("fs_one_cycle_b", 64'(fs_b), 64'd0);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
    $fatal(1, "watchdog expired");
  end

endmodule
